// File: rtl/mmio_console.sv
// Memory-mapped console/exit device: one-deep request/response port, a print FIFO
// and a sticky done/exit-code register. MMIO_CONSOLE_DROP_ON_FULL_EN selects drop-on-full.
module mmio_console #(
  parameter int unsigned      XLEN       = 32,
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter logic [XLEN-1:0]  DONE_ADDR  = 32'h0000_0100,
  parameter logic [XLEN-1:0]  PRINT_ADDR = 32'h0000_0104
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_rdata,
  output logic              rsp_error,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              done,
  output logic [XLEN-1:0]   exit_code
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
  ,
  output logic [15:0]       drop_count
`endif
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic                             ready_q, ready_d;
  logic                             rsp_valid_q, rsp_valid_d;
  logic [XLEN-1:0]                  rsp_rdata_q, rsp_rdata_d;
  logic                             rsp_error_q, rsp_error_d;
  logic                             done_q, done_d;
  logic [XLEN-1:0]                  exit_q, exit_d;
  logic [FIFO_DEPTH-1:0][7:0]       mem_q, mem_d;
  logic [PW-1:0]                    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
  logic [15:0]                      drop_q, drop_d;
`endif

  logic is_done, is_print, want_push, full, hs, push, pop;
  logic unused_wstrb;

  assign unused_wstrb = ^req_wstrb[XLEN/8-1:1];

  always_comb begin
    is_done     = (req_addr == DONE_ADDR);
    is_print    = (req_addr == PRINT_ADDR);
    want_push   = req_write && is_print && req_wstrb[0];
    full        = (cnt_q == CW'(FIFO_DEPTH));
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
    req_ready   = ready_q && !rsp_valid_q;
`else
    // Only a byte that would actually be pushed is held off by a full FIFO.
    req_ready   = ready_q && !rsp_valid_q && !(want_push && full);
`endif
    hs          = req_valid && req_ready;
    pop         = out_valid && out_ready;
    push        = hs && want_push && !full;

    ready_d     = 1'b1;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_error_d = rsp_error_q;
    done_d      = done_q;
    exit_d      = exit_q;
    mem_d       = mem_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
    drop_d      = drop_q;
`endif

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;

    if (hs) begin
      rsp_valid_d = 1'b1;
      rsp_rdata_d = '0;
      rsp_error_d = 1'b0;
      if (is_done) begin
        if (req_write) begin
          if (!done_q) begin
            done_d = 1'b1;
            exit_d = req_wdata;
          end
        end else begin
          rsp_rdata_d = XLEN'(done_q);
        end
      end else if (is_print) begin
        if (!req_write) rsp_rdata_d = XLEN'(cnt_q);
      end else begin
        rsp_error_d = 1'b1;
      end
    end

    if (push) begin
      mem_d[wr_q] = req_wdata[7:0];
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
    if (hs && want_push && full && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      done_q      <= 1'b0;
      exit_q      <= '0;
      mem_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      cnt_q       <= '0;
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
      drop_q      <= '0;
`endif
    end else begin
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
      done_q      <= done_d;
      exit_q      <= exit_d;
      mem_q       <= mem_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
      drop_q      <= drop_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;
  assign done      = done_q;
  assign exit_code = exit_q;
  assign out_valid = (cnt_q != '0);
  // Head is gated so out_data reads zero whenever the FIFO is empty.
  assign out_data  = out_valid ? mem_q[rd_q] : 8'h00;
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_mmio_console.sv
// Self-checking bench for mmio_console: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_mmio_console;
  localparam int          XLEN  = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] DA    = 32'h0000_0100;
  localparam logic [31:0] PA    = 32'h0000_0104;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        out_valid, out_ready;
  logic [7:0]  out_data;
  logic        done;
  logic [31:0] exit_code;
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
  logic [15:0] drop_count;
`endif

  mmio_console #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .DONE_ADDR(DA), .PRINT_ADDR(PA)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .exit_code(exit_code)
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
    , .drop_count(drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  mq[$];
  bit          m_started, m_rv, m_re, m_done;
  logic [31:0] m_rd, m_exit;
  int          m_drops;

  function automatic bit is_push_req();
    return req_write && (req_addr == PA) && req_wstrb[0];
  endfunction

  function automatic bit exp_ready();
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
    return m_started && !m_rv;
`else
    return m_started && !m_rv && !(is_push_req() && mq.size() == DEPTH);
`endif
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_started = 0; m_rv = 0; m_re = 0; m_done = 0;
      m_rd = 0; m_exit = 0; m_drops = 0;
    end else begin
      bit hs, pop;
      int pre;
      hs  = req_valid && exp_ready();
      pre = mq.size();
      pop = (pre != 0) && out_ready;
      if (m_rv && rsp_ready) m_rv = 0;
      if (pop) void'(mq.pop_front());
      if (hs) begin
        m_rv = 1; m_rd = 0; m_re = 0;
        if (req_addr == DA) begin
          if (req_write) begin
            if (!m_done) begin m_done = 1; m_exit = req_wdata; end
          end else m_rd = {31'd0, m_done};
        end else if (req_addr == PA) begin
          if (!req_write) m_rd = pre;
          else if (req_wstrb[0]) begin
            if (pre < DEPTH) mq.push_back(req_wdata[7:0]);
            else if (m_drops < 65535) m_drops++;
          end
        end else m_re = 1;
      end
      m_started = 1;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready, exp_ready());
    chk("rsp_valid", rsp_valid, m_rv);
    chk("rsp_rdata", rsp_rdata, m_rd);
    chk("rsp_error", rsp_error, m_re);
    chk("out_valid", out_valid, mq.size() != 0);
    chk("out_data", out_data, (mq.size() != 0) ? mq[0] : 8'h00);
    chk("done", done, m_done);
    chk("exit_code", exit_code, m_exit);
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
    chk("drop_count", drop_count, m_drops);
`endif
  end

  logic [7:0] pop_log[$];
  always @(posedge clk) if (rst_n && out_valid && out_ready) pop_log.push_back(out_data);

  bit rnd = 0;
  initial forever begin
    @(posedge clk); #1;
    if (rnd) begin
      out_ready = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom % 4) != 0;
    end
  end

  // Called at posedge+1; returns at posedge+1.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] ws, input bit wait_rsp,
                        output logic [31:0] rd, output logic er);
    bit ok = 0;
    rd = 0; er = 0;
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; req_wstrb = ws;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (req_ready) begin ok = 1; @(posedge clk); #1; break; end
      @(posedge clk); #1;
    end
    req_valid = 0;
    if (!ok) chk("hs_timeout", 0, 1);
    if (wait_rsp && ok) begin
      ok = 0;
      for (int i = 0; i < 300; i++) begin
        if (rsp_valid && rsp_ready) begin
          ok = 1; rd = rsp_rdata; er = rsp_error;
          @(posedge clk); #1; break;
        end
        @(posedge clk); #1;
      end
      if (!ok) chk("rsp_timeout", 0, 1);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] rd, r0;
  logic        er;

  initial begin
    rst_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
    rsp_ready = 1; out_ready = 0;
    #2;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_exit", exit_code, 0);
    cyc(3);
    rst_n = 1;
    cyc(1);
    chk("ready_after_rst", req_ready, 1);

    // Two print bytes drain in order.
    out_ready = 1; pop_log.delete();
    do_req(1, PA, 32'h41, 4'h1, 1, rd, er); chk("p41_err", er, 0);
    do_req(1, PA, 32'h42, 4'h1, 1, rd, er); chk("p42_err", er, 0);
    cyc(4);
    chk("pop_cnt", pop_log.size(), 2);
    if (pop_log.size() == 2) begin
      chk("pop0", pop_log[0], 8'h41);
      chk("pop1", pop_log[1], 8'h42);
    end

    // Done register is sticky.
    do_req(1, DA, 32'h2A, 4'hF, 1, rd, er);
    chk("done_set", done, 1); chk("exit_2a", exit_code, 32'h2A); chk("done_err", er, 0);
    do_req(1, DA, 32'h7, 4'hF, 1, rd, er);
    chk("exit_kept", exit_code, 32'h2A); chk("done2_err", er, 0);
    do_req(0, DA, 0, 4'h0, 1, rd, er); chk("ld_done", rd, 1);

    // Unmapped load and occupancy load.
    do_req(0, 32'h108, 0, 4'h0, 1, rd, er);
    chk("unmapped_err", er, 1); chk("unmapped_rd", rd, 0);
    out_ready = 0;
    do_req(1, PA, 32'h61, 4'h1, 1, rd, er);
    do_req(1, PA, 32'h62, 4'h1, 1, rd, er);
    do_req(1, PA, 32'h63, 4'h1, 1, rd, er);
    do_req(1, PA, 32'h64, 4'h0, 1, rd, er); chk("nostrb_err", er, 0);
    do_req(0, PA, 0, 4'h0, 1, rd, er); chk("occ3", rd, 3);

    // Response held under back-pressure.
    rsp_ready = 0;
    do_req(0, PA, 0, 4'h0, 0, rd, er);
    r0 = rsp_rdata;
    chk("held_val", r0, 3);
    for (int i = 0; i < 5; i++) begin
      chk("held_valid", rsp_valid, 1);
      chk("held_rdata", rsp_rdata, r0);
      chk("held_noready", req_ready, 0);
      cyc(1);
    end
    rsp_ready = 1; cyc(1);

    // Fill to 8, then the 9th print store.
    for (int i = 0; i < 5; i++) do_req(1, PA, 32'h70 + i, 4'h1, 1, rd, er);
`ifdef MMIO_CONSOLE_DROP_ON_FULL_EN
    do_req(1, PA, 32'h39, 4'h1, 1, rd, er);
    chk("drop_err", er, 0);
    chk("drop_cnt1", drop_count, 1);
    chk("still_full", out_valid, 1);
`else
    req_valid = 1; req_write = 1; req_addr = PA; req_wdata = 32'h39; req_wstrb = 4'h1;
    for (int i = 0; i < 4; i++) begin #1; chk("full_stall", req_ready, 0); cyc(1); end
    req_write = 0; #1; chk("full_load_ok", req_ready, 1);
    req_write = 1;
    out_ready = 1; #1;
    chk("pop_no_unblock", req_ready, 0);
    cyc(1); out_ready = 0;
    #1; chk("unblocked", req_ready, 1);
    do_req(1, PA, 32'h39, 4'h1, 1, rd, er);
    chk("p9_err", er, 0);
`endif
    out_ready = 1; cyc(20);

    // Asynchronous reset with a queued FIFO and a pending response.
    out_ready = 0;
    for (int i = 0; i < 4; i++) do_req(1, PA, 32'h50 + i, 4'h1, 1, rd, er);
    rsp_ready = 0;
    do_req(0, DA, 0, 4'h0, 0, rd, er);
    @(posedge clk); #3;
    rst_n = 0; #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_req_ready", req_ready, 0);
    chk("arst_done", done, 0);
    cyc(2); rst_n = 1; rsp_ready = 1; cyc(2);

    // Randomized traffic.
    rnd = 1;
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      case ($urandom % 8)
        0:       a = DA;
        1, 2:    a = 32'h108;
        3:       a = $urandom;
        default: a = PA;
      endcase
      do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 0, rd, er);
      cyc($urandom_range(0, 2));
    end
    rnd = 0; out_ready = 1; rsp_ready = 1;
    cyc(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
